// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer: COUNT/COMPARE match with autoreload or one-shot, level irq.
// Optional external capture input (synchronised cap_in edge latches COUNT) when MMIO_TIMER_CAPTURE_EN is defined.
module mmio_timer #(
  parameter int DATA_WIDTH = 32,
  parameter int PRESCALE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            addr,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  input  logic                  cap_in,
  output logic                  irq
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic                  ctrl_run, ctrl_ar, ctrl_ie;
  logic [DATA_WIDTH-1:0] count, compare, capture;
  logic                  st_match, st_cap;
  logic [PW-1:0]         presc;
  logic                  wr_ctrl, wr_count, wr_cmp, wr_status;
  logic                  tick, hit, cap_edge;

  assign wr_ctrl   = en && (addr == 3'd0);
  assign wr_count  = en && (addr == 3'd1);
  assign wr_cmp    = en && (addr == 3'd2);
  assign wr_status = en && (addr == 3'd3);

  assign tick = ctrl_run && (presc == PRESC_LAST);
  // A software COUNT write in a tick cycle suppresses the match evaluation entirely.
  assign hit  = tick && (count == compare) && !wr_count;

`ifdef MMIO_TIMER_CAPTURE_EN
  logic [2:0] cap_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_sync <= '0;
      capture  <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], cap_in};
      if (cap_edge) capture <= count;
    end
  end

  assign cap_edge = cap_sync[1] && !cap_sync[2];
`else
  logic unused_cap_in;
  assign unused_cap_in = cap_in;
  assign cap_edge      = 1'b0;
  assign capture       = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_run <= 1'b0;
      ctrl_ar  <= 1'b0;
      ctrl_ie  <= 1'b0;
      count    <= '0;
      compare  <= '0;
      st_match <= 1'b0;
      st_cap   <= 1'b0;
      presc    <= '0;
    end else begin
      if (!ctrl_run || tick) presc <= '0;
      else                   presc <= presc + 1'b1;

      if (wr_ctrl)              {ctrl_ie, ctrl_ar, ctrl_run} <= DataIn[2:0];
      else if (hit && !ctrl_ar) ctrl_run <= 1'b0;

      if (wr_count)                       count <= DataIn;
      else if (tick && (count != compare)) count <= count + 1'b1;
      else if (hit && ctrl_ar)            count <= '0;

      if (wr_cmp) compare <= DataIn;

      // New events win over a simultaneous write-1-to-clear.
      st_match <= hit      || (st_match && !(wr_status && DataIn[0]));
      st_cap   <= cap_edge || (st_cap   && !(wr_status && DataIn[1]));
    end
  end

  assign irq = (st_match || st_cap) && ctrl_ie;

  always_comb begin
    DataOut = '0;
    case (addr)
      3'd0:    DataOut[2:0] = {ctrl_ie, ctrl_ar, ctrl_run};
      3'd1:    DataOut      = count;
      3'd2:    DataOut      = compare;
      3'd3:    DataOut[1:0] = {st_cap, st_match};
      3'd4:    DataOut      = capture;
      default: DataOut      = '0;
    endcase
  end
endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios with literal expectations plus
// randomized bus traffic compared every cycle against an integer-level reference model.
module tb_mmio_timer;
  localparam int DW = 32;
  localparam int PS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          cap_in = 1'b0;
  logic [2:0]    addr = '0;
  logic [DW-1:0] DataIn = '0;
  logic [DW-1:0] DataOut;
  logic          irq;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  mmio_timer #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .DataIn(DataIn),
    .DataOut(DataOut), .cap_in(cap_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: registers as plain integers, prescaler as cycles elapsed in the current tick period.
  bit              m_run, m_ar, m_ie, m_match, m_cap;
  longint unsigned m_count, m_cmp;
  int              m_elapsed;
`ifdef MMIO_TIMER_CAPTURE_EN
  longint unsigned m_capture;
  bit [2:0]        m_hist;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_ar = 0; m_ie = 0; m_match = 0; m_cap = 0;
      m_count = 0; m_cmp = 0; m_elapsed = 0;
`ifdef MMIO_TIMER_CAPTURE_EN
      m_capture = 0; m_hist = 0;
`endif
    end else begin
      bit tick, hit, cap_ev;
      longint unsigned old_count;
      tick = m_run && (m_elapsed == PS - 1);
      hit  = tick && (m_count == m_cmp) && !(en && addr == 3'd1);
      cap_ev = 0;
`ifdef MMIO_TIMER_CAPTURE_EN
      cap_ev = m_hist[1] && !m_hist[2];
      m_hist = {m_hist[1:0], cap_in};
`endif
      old_count = m_count;
      m_elapsed = (m_run && !tick) ? m_elapsed + 1 : 0;
      if (tick && m_count != m_cmp) m_count = (m_count + 1) % (64'd1 << DW);
      else if (hit && m_ar) m_count = 0;
      if (hit && !m_ar) m_run = 0;
      if (en) begin
        case (addr)
          3'd0: {m_ie, m_ar, m_run} = DataIn[2:0];
          3'd1: m_count = DataIn;
          3'd2: m_cmp = DataIn;
          3'd3: begin
            if (DataIn[0]) m_match = 0;
            if (DataIn[1]) m_cap = 0;
          end
          default: ;
        endcase
      end
      if (hit) m_match = 1;
      if (cap_ev) begin
        m_cap = 1;
`ifdef MMIO_TIMER_CAPTURE_EN
        m_capture = old_count;
`endif
      end
    end
  end

  function automatic logic [63:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 64'({m_ie, m_ar, m_run});
      3'd1: return m_count;
      3'd2: return m_cmp;
      3'd3: return 64'({m_cap, m_match});
`ifdef MMIO_TIMER_CAPTURE_EN
      3'd4: return m_capture;
`endif
      default: return 64'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_read", DataOut, m_read(addr));
      chk("model_irq", irq, (m_match || m_cap) && m_ie);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    en = 1'b1; addr = a; DataIn = d;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [DW-1:0] d);
    addr = a; #1;
    d = DataOut;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [DW-1:0] d;
  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      en = 1'($urandom); addr = 3'($urandom); DataIn = $urandom; cap_in = 1'($urandom);
      @(posedge clk); #1;
    end
    en = 1'b0; cap_in = 1'b0; rst = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk("reset_read", d, 0);
      idle(1);
    end
    chk("reset_irq", irq, 0);

    // Autoreload: COMPARE=3 gives a match every 16 cycles
    wr(3'd2, 3);
    wr(3'd0, 7);
    wait_irq(n);
    chk("ar_first_match_cycles", n, 16);
    rd(3'd1, d);
    chk("ar_count_reloaded", d, 0);
    wr(3'd3, 1);
    chk("ar_irq_cleared", irq, 0);
    wait_irq(n);
    chk("ar_second_match_cycles", n + 1, 16);
    wr(3'd0, 0); wr(3'd3, 1); wr(3'd1, 0);

    // One-shot: COMPARE=2 matches 12 cycles after start and stops
    wr(3'd2, 2);
    wr(3'd0, 5);
    wait_irq(n);
    chk("os_match_cycles", n, 12);
    idle(20);
    rd(3'd0, d);
    chk("os_run_cleared", d, 4);
    rd(3'd1, d);
    chk("os_count_held", d, 2);
    wr(3'd0, 0); wr(3'd3, 1); wr(3'd1, 0);

    // COUNT write in a tick cycle wins over the increment
    wr(3'd2, 100);
    wr(3'd0, 1);
    idle(7);
    wr(3'd1, 32'h10);
    rd(3'd1, d);
    chk("coll_count_write", d, 32'h10);
    wr(3'd0, 0); wr(3'd1, 0);

    // W1C of match colliding with a new match: set wins
    wr(3'd2, 3);
    wr(3'd0, 3);
    idle(16);
    wr(3'd3, 1);
    rd(3'd3, d);
    chk("w1c_plain_clear", d, 0);
    idle(14);
    wr(3'd3, 1);
    rd(3'd3, d);
    chk("w1c_vs_set", d, 1);
    wr(3'd3, 1);
    rd(3'd3, d);
    chk("w1c_after", d, 0);
    wr(3'd0, 0); wr(3'd1, 0);

    // Wrap through 2^32 before matching
    wr(3'd2, 1);
    wr(3'd1, 32'hFFFF_FFFE);
    wr(3'd0, 1);
    idle(4);
    rd(3'd1, d); chk("wrap_ffffffff", d, 32'hFFFF_FFFF);
    idle(4);
    rd(3'd1, d); chk("wrap_zero", d, 0);
    idle(4);
    rd(3'd1, d); chk("wrap_one", d, 1);
    rd(3'd3, d); chk("wrap_no_match_yet", d, 0);
    idle(4);
    rd(3'd3, d); chk("wrap_match", d, 1);
    rd(3'd0, d); chk("wrap_oneshot_stop", d, 0);
    wr(3'd3, 3);

    // Capture input
    wr(3'd0, 4);
    wr(3'd1, 5);
    cap_in = 1'b1;
    idle(3);
    rd(3'd4, d);
`ifdef MMIO_TIMER_CAPTURE_EN
    chk("cap_value", d, 5);
    rd(3'd3, d); chk("cap_status", d, 2);
    chk("cap_irq", irq, 1);
`else
    chk("cap_disabled_read", d, 0);
    rd(3'd3, d); chk("cap_disabled_status", d, 0);
    chk("cap_disabled_irq", irq, 0);
`endif
    cap_in = 1'b0;
    wr(3'd3, 3); wr(3'd0, 0); wr(3'd1, 0);

    // Reset mid-count aborts immediately
    wr(3'd2, 5);
    wr(3'd0, 7);
    idle(30);
    rd(3'd1, d);
    chk("pre_reset_count", d, 1);
    chk("pre_reset_irq", irq, 1);
    rst = 1'b0; #1;
    chk("async_reset_count", DataOut, 0);
    chk("async_reset_irq", irq, 0);
    idle(2);
    rst = 1'b1;

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      addr = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 99) < 15);
      case (addr)
        3'd1, 3'd2: DataIn = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 12);
        default:    DataIn = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) cap_in = ~cap_in;
      @(posedge clk); #1;
    end
    en = 1'b0;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral; the responder side of the core's load/store peripheral bus.
- Attaches beside the GPIO and UART blocks behind the memory controller, which drives its write-enable, word address and store data.
- Returns read data to the peripheral read mux.
- Counts prescaled clock ticks, flags compare matches, raises a level interrupt.

Parameters:
- DATA_WIDTH, 32, bus data width; counter/compare width equals DATA_WIDTH.
- PRESCALE, 4, clk cycles per timer tick; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  write strobe from memory controller, one cycle per store.
- addr  input  3  word select, driven from bus address bits [4:2].
- DataIn  input  DATA_WIDTH  store data.
- DataOut  output  DATA_WIDTH  read data, combinational from addr.
- cap_in  input  1  external capture pin, asynchronous; used only with the optional feature.
- irq  output  1  level interrupt = STATUS.match & CTRL.ie.

Behaviour:
- Register map (addr):
  - 0 CTRL: bit0 run, bit1 autoreload, bit2 ie; other bits read 0.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: bit0 match, bit1 cap; write-1-to-clear.
  - 4 CAPTURE: read-only.
  - 5-7: read 0, writes ignored.
- Reset (rst=0, async): CTRL, COUNT, COMPARE, STATUS, CAPTURE and prescaler are all 0. DataOut reflects zeroed registers. irq=0. Reset mid-count aborts immediately; no pending match survives.
- Writes: take effect on the rising edge where en=1. Full-word writes only.
- Prescaler: counts 0..PRESCALE-1 while run=1; held at 0 while run=0.
  - tick = run & (presc==PRESCALE-1).
  - PRESCALE=1 gives a tick every cycle while run=1.
- On tick:
  - If COUNT==COMPARE: set STATUS.match. If autoreload=1, COUNT<=0 and counting continues. If autoreload=0, COUNT holds and CTRL.run<=0 (one-shot).
  - Otherwise COUNT<=COUNT+1, wrapping modulo 2^DATA_WIDTH.
  - Match period = (COMPARE+1)*PRESCALE cycles measured from the run 0->1 write.
- Simultaneous events:
  - Software write to COUNT in a tick cycle: written value wins; no increment; no match evaluated that cycle.
  - Software write to CTRL in a one-shot match cycle: written value wins.
  - W1C of match in the same cycle a new match sets it: set wins.
  - Write to COMPARE in a tick cycle: the match compare uses the old COMPARE.
- COMPARE < COUNT while running: count wraps through 2^DATA_WIDTH before matching.
- irq: combinational from registered bits. Asserted from the cycle after the match edge until match is cleared or ie=0.
- Read path: zero-latency combinational mux, consistent with the existing peripheral read mux timing. No read side effects.

Optional Feature:
- Macro: MMIO_TIMER_CAPTURE_EN.
- When defined:
  - cap_in passes a 2-flop synchronizer, then rising-edge detect.
  - On a detected edge, CAPTURE<=COUNT and STATUS.cap is set.
  - Edge-to-capture latency is 3 clk cycles.
  - If the edge coincides with a COUNT write, CAPTURE takes the pre-write COUNT.
  - irq = (match | cap) & ie.
  - Synchronizer flops reset to 0.
- When undefined:
  - cap_in is ignored; no synchronizer logic.
  - addr 4 reads 0; STATUS.cap reads 0.
  - irq = match & ie.

Test Plan:
- Reset: hold rst=0 with random bus activity, release -> every addr reads 0, irq=0. Assert rst=0 mid-count -> COUNT reads 0 the same cycle, irq drops immediately.
- Autoreload: PRESCALE=4, COMPARE=3, CTRL=0x7 -> first match edge 16 cycles after the CTRL write; irq=1. After W1C STATUS=1, next match 16 cycles later; COUNT sequence 0,1,2,3,0.
- One-shot: COMPARE=2, CTRL=0x5 -> match at cycle 12, then run reads 0 and COUNT holds at 2 indefinitely.
- Collision: write COUNT=0x10 in a tick cycle -> COUNT reads 0x10, not 0x11. W1C match in the same cycle as a new match -> match stays 1.
- Wrap: COUNT=0xFFFFFFFE, COMPARE=1, PRESCALE=4 -> COUNT goes 0xFFFFFFFF, 0, 1, then match.
- Capture (MMIO_TIMER_CAPTURE_EN defined): pulse cap_in while COUNT=5 stable -> CAPTURE=5 and STATUS=0x2 three cycles later; irq=1 with ie=1. With the macro undefined, addr 4 reads 0.
